// File: rtl/seq_accum_adder.sv
// seq_accum_adder: sequential accumulator that sums N_OPS operands per
// transaction on top of a one-bit carry seed. Handshake is start / in_valid /
// in_ready, with a one-cycle done pulse when the sum is final.
// Optional feature: define ACCUM_SATURATE_EN to clamp the sum to 2^WIDTH-1
// and flag ovf; without it the full-width sum is produced and ovf stays 0.
module seq_accum_adder #(
  parameter int WIDTH = 3,
  parameter int N_OPS = 8,
  localparam int SW = WIDTH + $clog2(N_OPS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SW-1:0]    sum,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  // Beat counter is one bit wider than needed so N_OPS-1 always fits,
  // including the N_OPS = 2^k cases.
  localparam int CW = $clog2(N_OPS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N_OPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t        state_q;
  logic [SW-1:0] acc_q;
  logic [SW-1:0] acc_d;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          busy_q;
  logic          inReady_q;
  logic          ovf_q;
  logic          ovf_d;
  logic [SW-1:0] aExt;
  logic [SW-1:0] rawSum;
  logic          beat;

  assign aExt   = {{(SW-WIDTH){1'b0}}, a};
  assign rawSum = acc_q + aExt;
  assign beat   = in_valid && inReady_q;

`ifdef ACCUM_SATURATE_EN
  localparam logic [SW-1:0] SAT_MAX = SW'((2 ** WIDTH) - 1);

  // Clamp the running total to the operand range and remember that it happened.
  always_comb begin
    acc_d = rawSum;
    ovf_d = ovf_q;
    if (rawSum > SAT_MAX) begin
      acc_d = SAT_MAX;
      ovf_d = 1'b1;
    end
  end
`else
  // Full-width accumulation; SW is sized so the total can never wrap.
  always_comb begin
    acc_d = rawSum;
    ovf_d = 1'b0;
  end
`endif

  // Control FSM with registered handshake/status outputs and the datapath regs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      inReady_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= ACCUM;
            acc_q     <= {{(SW-1){1'b0}}, c_in};
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b1;
            inReady_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q   <= DONE;
              inReady_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          inReady_q <= 1'b0;
        end
      endcase
    end
  end

  assign sum      = acc_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign in_ready = inReady_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_seq_accum_adder.sv
// tb_seq_accum_adder: directed bench for seq_accum_adder. Three instances
// (WIDTH/N_OPS = 3/8, 8/1, 4/8) share one stimulus; a transaction-level model
// predicts every output each cycle, and literal expectations pin the model.
module tb_seq_accum_adder;

`ifdef ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       c_in;
  logic       in_valid;
  logic [7:0] aWide;

  logic [6:0] sumA;
  logic       doneA, busyA, readyA, ovfA;
  logic [8:0] sumB;
  logic       doneB, busyB, readyB, ovfB;
  logic [7:0] sumC;
  logic       doneC, busyC, readyC, ovfC;

  int  checks = 0;
  int  errors = 0;
  bit  checking = 1'b0;

  int  mPhase[3];
  int  mTotal[3];
  int  mBeats[3];

  seq_accum_adder #(.WIDTH(3), .N_OPS(8)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in), .a(aWide[2:0]),
    .in_valid(in_valid), .in_ready(readyA), .sum(sumA), .done(doneA),
    .busy(busyA), .ovf(ovfA)
  );

  seq_accum_adder #(.WIDTH(8), .N_OPS(1)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in), .a(aWide),
    .in_valid(in_valid), .in_ready(readyB), .sum(sumB), .done(doneB),
    .busy(busyB), .ovf(ovfB)
  );

  seq_accum_adder #(.WIDTH(4), .N_OPS(8)) dutC (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in), .a(aWide[3:0]),
    .in_valid(in_valid), .in_ready(readyC), .sum(sumC), .done(doneC),
    .busy(busyC), .ovf(ovfC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int widthOf(int d);
    case (d)
      0: return 3;
      1: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int nOpsOf(int d);
    return (d == 1) ? 1 : 8;
  endfunction

  // which: 0 sum, 1 done, 2 busy, 3 in_ready, 4 ovf
  function automatic int actOut(int d, int which);
    logic [8:0] s;
    logic [3:0] f;
    case (d)
      0: begin s = {2'b00, sumA}; f = {doneA, busyA, readyA, ovfA}; end
      1: begin s = sumB;          f = {doneB, busyB, readyB, ovfB}; end
      default: begin s = {1'b0, sumC}; f = {doneC, busyC, readyC, ovfC}; end
    endcase
    case (which)
      0: return int'(s);
      1: return int'(f[3]);
      2: return int'(f[2]);
      3: return int'(f[1]);
      default: return int'(f[0]);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit st, input bit ci, input bit vld, input int av);
    start    = st;
    c_in     = ci;
    in_valid = vld;
    aWide    = 8'(av);
  endtask

  // Transaction model: idle / collecting / final-cycle phases, an unbounded
  // running total, and the number of operands taken so far.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int maxv;
      int av;
      maxv = (1 << widthOf(d)) - 1;
      av   = int'(aWide) & maxv;
      if (!rst_n) begin
        mPhase[d] = 0;
        mTotal[d] = 0;
        mBeats[d] = 0;
      end else begin
        case (mPhase[d])
          0: if (start) begin
            mPhase[d] = 1;
            mTotal[d] = int'(c_in);
            mBeats[d] = 0;
          end
          1: if (in_valid) begin
            mTotal[d] += av;
            mBeats[d]++;
            if (mBeats[d] == nOpsOf(d)) mPhase[d] = 2;
          end
          default: mPhase[d] = 0;
        endcase
      end
    end
  end

  // Compare every DUT output against the model shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      for (int d = 0; d < 3; d++) begin
        int maxv;
        int expSum;
        maxv   = (1 << widthOf(d)) - 1;
        expSum = (SAT && mTotal[d] > maxv) ? maxv : mTotal[d];
        checkOutput($sformatf("dut%0d sum", d), actOut(d, 0), expSum);
        checkOutput($sformatf("dut%0d done", d), actOut(d, 1), int'(mPhase[d] == 2));
        checkOutput($sformatf("dut%0d busy", d), actOut(d, 2), int'(mPhase[d] != 0));
        checkOutput($sformatf("dut%0d in_ready", d), actOut(d, 3), int'(mPhase[d] == 1));
        checkOutput($sformatf("dut%0d ovf", d), actOut(d, 4), int'(SAT && mTotal[d] > maxv));
      end
    end
  end

  initial begin
    int doneCnt;
    int held;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    tick();
    checking = 1'b1;
    checkOutput("reset sumA", int'(sumA), 0);
    checkOutput("reset busyA", int'(busyA), 0);
    checkOutput("reset readyA", int'(readyA), 0);
    checkOutput("reset doneA", int'(doneA), 0);
    checkOutput("reset ovfA", int'(ovfA), 0);
    rst_n = 1'b1;

    // 8 back-to-back beats of 7 on a carry seed of 1
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 7);
      tick();
      if (i == 0) begin
        checkOutput("first beat sumA", int'(sumA), SAT ? 7 : 8);
        checkOutput("first beat ovfA", int'(ovfA), SAT ? 1 : 0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("full sumA", int'(sumA), SAT ? 7 : 57);
    checkOutput("full doneA", int'(doneA), 1);
    checkOutput("full ovfA", int'(ovfA), SAT ? 1 : 0);
    tick();
    checkOutput("after done busyA", int'(busyA), 0);
    checkOutput("after done doneA", int'(doneA), 0);
    checkOutput("idle hold sumA", int'(sumA), SAT ? 7 : 57);
    checkOutput("idle hold ovfA", int'(ovfA), SAT ? 1 : 0);

    // Backpressure: operands 1..8 with 1-3 idle cycles between them
    doneCnt = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, i);
      tick();
      doneCnt += int'(doneC);
      applyStimulus(1'b0, 1'b0, 1'b0, 0);
      for (int g = 0; g < (i % 3) + 1; g++) begin
        tick();
        doneCnt += int'(doneC);
      end
    end
    tick();
    doneCnt += int'(doneC);
    checkOutput("backpressure sumC", int'(sumC), SAT ? 15 : 36);
    checkOutput("backpressure done pulses", doneCnt, 1);
    checkOutput("backpressure sumA", int'(sumA), SAT ? 7 : 28);

    // Reset after the third beat, then an independent transaction
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    tick();
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, i);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    tick();
    checkOutput("mid reset sumA", int'(sumA), 0);
    checkOutput("mid reset busyA", int'(busyA), 0);
    checkOutput("mid reset readyA", int'(readyA), 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, i);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("post reset sumA", int'(sumA), SAT ? 7 : 29);
    checkOutput("post reset doneA", int'(doneA), 1);
    checkOutput("post reset sumC", int'(sumC), SAT ? 15 : 29);
    tick();

    // start held high through ACCUM and DONE
    doneCnt = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      tick();
      doneCnt += int'(doneA);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    held = SAT ? 7 : 8;
    checkOutput("held start sumA", int'(sumA), held);
    checkOutput("held start doneA", int'(doneA), 1);
    tick();
    doneCnt += int'(doneA);
    checkOutput("held start idle busyA", int'(busyA), 0);
    checkOutput("held start idle sumA", int'(sumA), held);
    tick();
    doneCnt += int'(doneA);
    checkOutput("held start restart busyA", int'(busyA), 1);
    checkOutput("held start restart readyA", int'(readyA), 1);
    checkOutput("held start restart sumA", int'(sumA), 0);
    checkOutput("held start done pulses", doneCnt, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single-operand instance: 1 + 255
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 255);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("single op sumB", int'(sumB), SAT ? 255 : 256);
    checkOutput("single op doneB", int'(doneB), 1);
    checkOutput("single op ovfB", int'(ovfB), SAT ? 1 : 0);
    tick();
    checkOutput("single op after doneB", int'(doneB), 0);
    checkOutput("single op after busyB", int'(busyB), 0);
    checkOutput("single op hold sumB", int'(sumB), SAT ? 255 : 256);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
